// File: rtl/id_control_if.sv
// Decode-stage bus: fetch-facing control plus the registered ID/EX slot.
interface id_control_if #(
  parameter int REG_W = 4,
  parameter int OFF_W = 24
);
  logic [15:0]      instruction;
  logic             flagZ;
  logic             brTaken;
  logic [OFF_W-1:0] brOffset;
  logic             freeze;
  logic             exValid;
  logic [3:0]       exOp;
  logic [REG_W-1:0] exRd;
  logic [REG_W-1:0] exRs1;
  logic [REG_W-1:0] exRs2;
  logic [15:0]      exImm;
  logic             exWrEn;

  modport master (
    output instruction, flagZ,
    input  brTaken, brOffset, freeze,
    input  exValid, exOp, exRd, exRs1, exRs2, exImm, exWrEn
  );

  modport slave (
    input  instruction, flagZ,
    output brTaken, brOffset, freeze,
    output exValid, exOp, exRd, exRs1, exRs2, exImm, exWrEn
  );
endinterface

// File: rtl/id_control.sv
// Decode control: branch resolution, load-use/flag hazard freeze, wrong-path
// squash, and the ID/EX register.
module id_control #(
  parameter int REG_W = 4,
  parameter int OFF_W = 24
) (
  input logic         clk,
  input logic         rst,
  id_control_if.slave bus
);

  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_HALT} state_t;

  typedef struct packed {
    logic             vld;
    logic [3:0]       op;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [15:0]      imm;
    logic             wr;
  } ex_t;

  state_t state_q, state_d;
  ex_t    ex_q, ex_d, iss;

  logic [3:0]       op;
  logic [REG_W-1:0] fa, fb, fc;
  logic is_alu, is_ld, is_st, is_b, is_beq, is_halt;
  logic prev_ld, prev_alu, lu_haz, flag_haz, taken;
  logic br, frz;

  always_comb begin
    op      = bus.instruction[15:12];
    fa      = bus.instruction[11:8];
    fb      = bus.instruction[7:4];
    fc      = bus.instruction[3:0];
    is_alu  = (op inside {[4'h1:4'h7]});
    is_ld   = (op == 4'h8);
    is_st   = (op == 4'h9);
    is_b    = (op == 4'hC);
    is_beq  = (op == 4'hD);
    is_halt = (op == 4'hF);

    prev_ld  = ex_q.vld && (ex_q.op == 4'h8);
    prev_alu = ex_q.vld && (ex_q.op inside {[4'h1:4'h7]});
    // STORE data register lives in [11:8], so it is a source, not a dest
    lu_haz   = prev_ld && (((is_alu || is_ld || is_st) && (ex_q.rd == fb)) ||
                           (is_alu && (ex_q.rd == fc)) ||
                           (is_st  && (ex_q.rd == fa)));
    flag_haz = is_beq && prev_alu;
    taken    = is_b || (is_beq && bus.flagZ);

    iss     = '0;
    iss.vld = 1'b1;
    iss.op  = (is_alu || is_ld || is_st || is_beq) ? op : 4'h0;
    iss.rd  = (is_alu || is_ld) ? fa : '0;
    iss.rs1 = (is_alu || is_ld || is_st) ? fb : '0;
    iss.rs2 = is_alu ? fc : (is_st ? fa : '0);
    iss.imm = (is_ld || is_st) ? {{12{fc[3]}}, fc} : 16'h0;
    iss.wr  = is_alu || is_ld;

    state_d = state_q;
    ex_d    = '0;
    br      = 1'b0;
    frz     = 1'b0;
    unique case (state_q)
      S_RUN: begin
        // HALT also freezes in its decode cycle so fetch stops on it
        if (is_halt) begin
          frz     = 1'b1;
          state_d = S_HALT;
        end else if (lu_haz || flag_haz) begin
          frz = 1'b1;
        end else if (taken) begin
          br      = 1'b1;
          state_d = S_FLUSH;
        end else begin
          ex_d = iss;
        end
      end
      S_FLUSH: state_d = S_RUN;
      S_HALT:  frz = 1'b1;
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_RUN;
      ex_q    <= '0;
    end else begin
      state_q <= state_d;
      ex_q    <= ex_d;
    end
  end

  assign bus.brTaken  = br;
  assign bus.brOffset = br ? {{(OFF_W-12){bus.instruction[11]}}, bus.instruction[11:0]} : '0;
  assign bus.freeze   = frz;
  assign bus.exValid  = ex_q.vld;
  assign bus.exOp     = ex_q.op;
  assign bus.exRd     = ex_q.rd;
  assign bus.exRs1    = ex_q.rs1;
  assign bus.exRs2    = ex_q.rs2;
  assign bus.exImm    = ex_q.imm;
  assign bus.exWrEn   = ex_q.wr;

endmodule

// File: tb/tb_id_control.sv
// Self-checking bench: directed test-plan sequences then random traffic,
// compared against a rule-level decode model.
module tb_id_control;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  id_control_if #(.REG_W(4), .OFF_W(24)) bus ();

  id_control #(.REG_W(4), .OFF_W(24)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // model state: halted / flushing flags and the expected ID/EX contents
  bit m_halt, m_flush;
  bit e_v, e_wr;
  int e_op, e_rd, e_rs1, e_rs2, e_imm;
  bit last_frz, last_br;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic [15:0] ins, input bit fz, input bit r, input bit chk_comb);
    int op, a, b, c;
    int src[$];
    bit alu, lu, fh, tk, x_br, x_frz, n_v, n_wr;
    int x_off, n_op, n_rd, n_rs1, n_rs2, n_imm;
    @(negedge clk);
    bus.instruction = ins;
    bus.flagZ       = fz;
    rst             = r;
    op = int'(ins) >> 12;
    a  = (int'(ins) >> 8) & 15;
    b  = (int'(ins) >> 4) & 15;
    c  = int'(ins) & 15;
    alu = (op >= 1 && op <= 7);
    if (alu) src = '{b, c};
    else if (op == 8) src = '{b};
    else if (op == 9) src = '{b, a};
    lu = 0;
    if (e_v && e_op == 8)
      foreach (src[i]) if (src[i] == e_rd) lu = 1;
    fh = (op == 13) && e_v && (e_op >= 1 && e_op <= 7);
    tk = (op == 12) || (op == 13 && fz);

    x_br = 0; x_frz = 0; x_off = 0;
    n_v = 0; n_wr = 0; n_op = 0; n_rd = 0; n_rs1 = 0; n_rs2 = 0; n_imm = 0;
    if (m_halt) x_frz = 1;
    else if (m_flush) m_flush = 0;
    else if (op == 15) begin x_frz = 1; m_halt = 1; end
    else if (lu || fh) x_frz = 1;
    else if (tk) begin
      x_br = 1;
      x_off = (((int'(ins) & 'hFFF) ^ 'h800) - 'h800) & 'hFFFFFF;
      m_flush = 1;
    end else begin
      n_v   = 1;
      n_op  = (alu || op == 8 || op == 9 || op == 13) ? op : 0;
      n_rd  = (alu || op == 8) ? a : 0;
      n_rs1 = (src.size() > 0) ? src[0] : 0;
      n_rs2 = alu ? c : (op == 9 ? a : 0);
      n_imm = (op == 8 || op == 9) ? (((c ^ 8) - 8) & 'hFFFF) : 0;
      n_wr  = alu || op == 8;
    end
    last_frz = x_frz;
    last_br  = x_br;

    #1;
    if (chk_comb) begin
      chk("brTaken",  32'(bus.brTaken),  32'(x_br));
      chk("freeze",   32'(bus.freeze),   32'(x_frz));
      chk("brOffset", 32'(bus.brOffset), 32'(x_off));
    end

    if (!r) begin
      m_halt = 0; m_flush = 0;
      n_v = 0; n_wr = 0; n_op = 0; n_rd = 0; n_rs1 = 0; n_rs2 = 0; n_imm = 0;
    end
    e_v = n_v; e_wr = n_wr; e_op = n_op; e_rd = n_rd;
    e_rs1 = n_rs1; e_rs2 = n_rs2; e_imm = n_imm;

    @(posedge clk);
    #1;
    chk("exValid", 32'(bus.exValid), 32'(e_v));
    chk("exOp",    32'(bus.exOp),    32'(e_op));
    chk("exRd",    32'(bus.exRd),    32'(e_rd));
    chk("exRs1",   32'(bus.exRs1),   32'(e_rs1));
    chk("exRs2",   32'(bus.exRs2),   32'(e_rs2));
    chk("exImm",   32'(bus.exImm),   32'(e_imm));
    chk("exWrEn",  32'(bus.exWrEn),  32'(e_wr));
  endtask

  logic [15:0] ins;
  int          pick;

  initial begin
    bus.instruction = 16'h0000;
    bus.flagZ       = 1'b0;
    // reset then ALU issue
    step(16'h1123, 0, 0, 0);
    step(16'h1123, 0, 0, 1);
    step(16'h1123, 0, 1, 1);
    // load-use
    step(16'h8512, 0, 1, 1);
    step(16'h2658, 0, 1, 1);
    step(16'h2658, 0, 1, 1);
    // unconditional branch, wrong path dropped
    step(16'hCFFE, 0, 1, 1);
    step(16'h1111, 0, 1, 1);
    step(16'h0000, 0, 1, 1);
    // BEQ after ALU, taken then not taken
    step(16'h1123, 0, 1, 1);
    step(16'hD004, 0, 1, 1);
    step(16'hD004, 1, 1, 1);
    step(16'h1111, 0, 1, 1);
    step(16'h1123, 0, 1, 1);
    step(16'hD004, 1, 1, 1);
    step(16'hD004, 0, 1, 1);
    // HALT and reset recovery
    for (int i = 0; i < 7; i++) step(16'hF000, 0, 1, 1);
    step(16'h0000, 0, 0, 1);
    step(16'h1123, 0, 1, 1);
    // reset in the flush cycle
    step(16'hC010, 0, 1, 1);
    step(16'h1111, 0, 0, 1);
    step(16'h1123, 0, 1, 1);

    // random traffic with a fetch model that honours freeze
    ins = 16'h0000;
    for (int i = 0; i < 600; i++) begin
      if (!last_frz || m_halt) begin
        pick = $urandom_range(0, 99);
        if (pick < 30)      ins[15:12] = 4'($urandom_range(1, 7));
        else if (pick < 50) ins[15:12] = 4'h8;
        else if (pick < 60) ins[15:12] = 4'h9;
        else if (pick < 68) ins[15:12] = 4'hC;
        else if (pick < 80) ins[15:12] = 4'hD;
        else if (pick < 82) ins[15:12] = 4'hF;
        else                ins[15:12] = 4'($urandom_range(0, 15));
        ins[11:8] = 4'($urandom_range(0, 3));
        ins[7:4]  = 4'($urandom_range(0, 3));
        ins[3:0]  = 4'($urandom);
        if ($urandom_range(0, 3) == 0) ins[11:0] = 12'($urandom);
      end
      step(ins, 1'($urandom), (m_halt && $urandom_range(0, 5) == 0) ||
                              $urandom_range(0, 60) == 0 ? 1'b0 : 1'b1, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
